// File: rtl/blink_code_arbiter.sv
// rtl/blink_code_arbiter.sv - round-robin owner of one status LED, plays a requester's code as blinks then a gap
module blink_code_arbiter #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int TICK_HZ     = 10,
  parameter int NUM_REQ     = 4,
  parameter int CODE_W      = 4,
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 3,
  parameter int GAP_TICKS   = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CODE_W-1:0]  code,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       done,
  output logic                       led
);

  localparam int TICKS_PER = CLK_FREQ_HZ / TICK_HZ;
  localparam int PS_W      = (TICKS_PER > 1) ? $clog2(TICKS_PER) : 1;
  localparam int PH_MAX    = (ON_TICKS > OFF_TICKS) ?
                             ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                             ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int PTR_W     = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [CODE_W-1:0]   rem_q, rem_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                led_q, led_d;

  logic                tick;
  logic                found;
  logic [PTR_W-1:0]    sel_idx;
  logic [PTR_W-1:0]    cand;
  logic [CODE_W-1:0]   code_arr [NUM_REQ];
  logic [CODE_W-1:0]   sel_code;

  assign tick = (presc_q == PS_W'(TICKS_PER - 1));

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      code_arr[i] = code[i*CODE_W +: CODE_W];
    end
  end

  // Walk downward in distance so the nearest set bit after the pointer wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign sel_code = code_arr[sel_idx];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    led_d   = led_q;
    if (state_q == S_IDLE) begin
      presc_d = '0;
      phase_d = '0;
      led_d   = 1'b0;
      busy_d  = 1'b0;
      grant_d = '0;
      if (found) begin
        grant_d = NUM_REQ'(1) << sel_idx;
        busy_d  = 1'b1;
        ptr_d   = sel_idx;
        rem_d   = sel_code;
        if (sel_code != '0) begin
          state_d = S_ON;
          led_d   = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        phase_d = phase_q + 1'b1;
      end
      case (state_q)
        S_ON: begin
          if (tick && phase_q == PH_W'(ON_TICKS - 1)) begin
            phase_d = '0;
            rem_d   = rem_q - 1'b1;
            led_d   = 1'b0;
            state_d = (rem_q == CODE_W'(1)) ? S_GAP : S_OFF;
          end
        end
        S_OFF: begin
          if (tick && phase_q == PH_W'(OFF_TICKS - 1)) begin
            phase_d = '0;
            led_d   = 1'b1;
            state_d = S_ON;
          end
        end
        default: begin
          if (tick && phase_q == PH_W'(GAP_TICKS - 1)) begin
            phase_d = '0;
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign led   = led_q;

endmodule

// File: tb/tb_blink_code_arbiter.sv
// tb/tb_blink_code_arbiter.sv - directed and randomized checks of blink_code_arbiter against a timeline model
module tb_blink_code_arbiter;

  localparam int TP  = 10;
  localparam int ONT = 2;
  localparam int OFT = 3;
  localparam int GPT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  grant;
  logic        busy, done, led;
  logic [3:0]  codes [4];

  int n_vec = 0;
  int n_bad = 0;
  int ptr_m = 3;

  assign code = {codes[3], codes[2], codes[1], codes[0]};

  always #5 clk = ~clk;

  blink_code_arbiter #(
    .CLK_FREQ_HZ(10), .TICK_HZ(1), .NUM_REQ(4), .CODE_W(4),
    .ON_TICKS(ONT), .OFF_TICKS(OFT), .GAP_TICKS(GPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code),
    .grant(grant), .busy(busy), .done(done), .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int seq_len(input int c);
    if (c == 0) return GPT * TP;
    return (c * ONT + (c - 1) * OFT + GPT) * TP;
  endfunction

  // t = cycles elapsed since the grant edge
  function automatic logic exp_led(input int c, input int t);
    int blink_cycles;
    blink_cycles = (c == 0) ? 0 : (c * ONT + (c - 1) * OFT) * TP;
    if (t >= blink_cycles) return 1'b0;
    return ((t % ((ONT + OFT) * TP)) < ONT * TP) ? 1'b1 : 1'b0;
  endfunction

  // Called at a negedge; drives rq and follows one whole sequence up to its done negedge.
  task automatic run_seq(input logic [3:0] rq, input bit chg, output int idx);
    int c, len, k;
    idx = -1;
    for (k = 1; k <= 4; k++) begin
      if (idx < 0 && rq[(ptr_m + k) % 4]) idx = (ptr_m + k) % 4;
    end
    ptr_m = idx;
    c   = int'(codes[idx]);
    len = seq_len(c);
    req = rq;
    for (int t = 0; t <= len; t++) begin
      @(negedge clk);
      if (chg && t == len / 2) codes[idx] = 4'($urandom_range(0, 15));
      if (t < len) begin
        if (t == 0) chk("grant", 32'(grant), 32'(1) << idx);
        chk("busy_seq", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("led", 32'(led), 32'(exp_led(c, t)));
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("grant_drop", 32'(grant), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("led_end", 32'(led), 32'd0);
      end
    end
  endtask

  task automatic idle_check();
    req = 4'b0000;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 3;
  endtask

  initial begin
    int idx;
    logic [3:0] rq;
    rst_n = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) codes[i] = 4'd0;
    @(negedge clk);
    do_reset();

    codes[0] = 4'd3;
    run_seq(4'b0001, 1'b0, idx);
    idle_check();

    codes[0] = 4'd0;
    run_seq(4'b0001, 1'b0, idx);
    idle_check();

    do_reset();
    for (int i = 0; i < 4; i++) codes[i] = 4'd1;
    for (int n = 0; n < 5; n++) run_seq(4'b1111, 1'b0, idx);
    idle_check();

    run_seq(4'b0010, 1'b0, idx);
    run_seq(4'b1010, 1'b0, idx);
    chk("rr_first", 32'(idx), 32'd3);
    run_seq(4'b0010, 1'b0, idx);
    idle_check();

    codes[0] = 4'd2;
    req = 4'b0001;
    @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'd1);
    repeat (5) @(negedge clk);
    chk("pre_rst_led", 32'(led), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_led", 32'(led), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    req = 4'b1001;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    ptr_m = 3;
    run_seq(4'b1001, 1'b0, idx);
    chk("post_rst_first", 32'(idx), 32'd0);
    run_seq(4'b1000, 1'b0, idx);
    idle_check();

    codes[0] = 4'd15;
    run_seq(4'b0001, 1'b1, idx);
    idle_check();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) codes[i] = 4'($urandom_range(0, 15));
      rq = 4'($urandom_range(1, 15));
      while (rq != 4'b0000) begin
        run_seq(rq, 1'b1, idx);
        rq[idx] = 1'b0;
      end
      idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
